// File: rtl/lsu_mem_port.sv
// LSU-to-scratchpad memory port: affine address generator driving one bank,
// store path straight through on grant, load path via a 2-entry credit FIFO.
module lsu_mem_port #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 10,
   parameter int CNT_W  = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_valid,
   input  logic              cfg_mode,
   input  logic [ADDR_W-1:0] cfg_base,
   input  logic [ADDR_W-1:0] cfg_stride,
   input  logic [CNT_W-1:0]  cfg_count,
   input  logic              st_valid,
   output logic              st_ready,
   input  logic [DATA_W-1:0] st_data,
   output logic              ld_valid,
   input  logic              ld_ready,
   output logic [DATA_W-1:0] ld_data,
   output logic              mem_req,
   input  logic              mem_gnt,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_FIN
   } state_t;

   state_t            state_q, state_d;
   logic              mode_q, mode_d;
   logic [ADDR_W-1:0] stride_q, stride_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [CNT_W-1:0]  issued_q, issued_d;
   logic              inflight_q, inflight_d;
   logic [DATA_W-1:0] fifo_q [2];
   logic [DATA_W-1:0] fifo_d [2];
   logic              wr_ptr_q, wr_ptr_d;
   logic              rd_ptr_q, rd_ptr_d;
   logic [1:0]        occ_q, occ_d;

   logic              push;
   logic              pop;
   logic              acc;
   logic [2:0]        credit;

   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      stride_d   = stride_q;
      addr_d     = addr_q;
      count_d    = count_q;
      issued_d   = issued_q;
      inflight_d = 1'b0;
      fifo_d     = fifo_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      occ_d      = occ_q;

      st_ready  = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_wdata = '0;
      mem_addr  = addr_q;
      busy      = (state_q != S_IDLE);
      done      = 1'b0;
      ld_valid  = (occ_q != 2'd0);
      ld_data   = ld_valid ? fifo_q[rd_ptr_q] : '0;
      acc       = 1'b0;
      push      = inflight_q;
      pop       = ld_valid & ld_ready;
      // a pop in the same cycle does not free a credit for this request
      credit    = {1'b0, occ_q} + {2'b00, inflight_q};

      unique case (state_q)
         S_IDLE: begin
            if (cfg_valid) begin
               mode_d   = cfg_mode;
               stride_d = cfg_stride;
               count_d  = cfg_count;
               addr_d   = cfg_base;
               issued_d = '0;
               state_d  = (cfg_count == '0) ? S_FIN : S_RUN;
            end
         end
         S_RUN: begin
            if (mode_q) begin
               st_ready  = mem_gnt;
               mem_req   = st_valid;
               mem_we    = 1'b1;
               mem_wdata = st_data;
            end else begin
               mem_req = (credit < 3'd2) && (issued_q < count_q);
            end
            acc = mem_req & mem_gnt;
            if (acc) begin
               addr_d     = addr_q + stride_q;
               issued_d   = issued_q + 1'b1;
               inflight_d = ~mode_q;
               if (issued_d == count_q)
                  state_d = mode_q ? S_FIN : S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (!inflight_q && occ_q == 2'd0)
               state_d = S_FIN;
         end
         S_FIN: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (push) begin
         fifo_d[wr_ptr_q] = mem_rdata;
         wr_ptr_d         = ~wr_ptr_q;
      end
      if (pop)
         rd_ptr_d = ~rd_ptr_q;
      occ_d = occ_q + {1'b0, push} - {1'b0, pop};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         mode_q     <= 1'b0;
         stride_q   <= '0;
         addr_q     <= '0;
         count_q    <= '0;
         issued_q   <= '0;
         inflight_q <= 1'b0;
         fifo_q[0]  <= '0;
         fifo_q[1]  <= '0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         occ_q      <= 2'd0;
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         stride_q   <= stride_d;
         addr_q     <= addr_d;
         count_q    <= count_d;
         issued_q   <= issued_d;
         inflight_q <= inflight_d;
         fifo_q[0]  <= fifo_d[0];
         fifo_q[1]  <= fifo_d[1];
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         occ_q      <= occ_d;
      end
   end

endmodule
